datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameters: none; all widths fixed (32-bit data, 32 x 32-bit registers).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Port order:
- clk, rst, PCWrite, PCWriteCon, IorD, mem_read_data, IR_write, RegDst, RegWrDst, reg_write
- ALUSrcA, ALUSrcB, alu_op, pc_src, zero, mem_adr, mem_write_data

REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- PCWrite  in  1  unconditional PC load.
- PCWriteCon  in  1  PC load when zero=1.
- IorD  in  1  memory address select: 0 PC, 1 ALUOut.
- mem_read_data  in  32  data from external memory (combinational read).
- IR_write  in  1  load IR from mem_read_data.
- RegDst  in  1  write register select: 0 rt (IR[20:16]), 1 rd (IR[15:11]).
- RegWrDst  in  2  write-data select: 00 ALUOut, 01 MDR, 10 PC (write register forced to 31), 11 ALUOut.
- reg_write  in  1  register-file write enable.
- ALUSrcA  in  1  ALU A operand: 0 PC, 1 A register.
- ALUSrcB  in  2  ALU B operand: 00 B register, 01 constant 4, 10 sign-extended IR[15:0], 11 sign-extended IR[15:0] shifted left 2.
- alu_op  in  3  000 add, 001 sub, 010 and, 011 or, 100 set-less-than signed, others add.
- pc_src  in  2  next PC: 00 ALU result, 01 ALUOut, 10 {PC[31:28], IR[25:0], 00}, 11 A register.
- zero  out  1  1 when the combinational ALU result equals 0.
- mem_adr  out  32  memory address per IorD.
- mem_write_data  out  32  B register contents.

Function
REQ-005 PC SHALL load the next-PC value on a rising edge when PCWrite | (PCWriteCon & zero).
REQ-006 IR SHALL load mem_read_data on a rising edge when IR_write=1; otherwise it holds.
REQ-007 MDR SHALL load mem_read_data every cycle.
REQ-008 A and B SHALL load register-file reads of rs=IR[25:21] and rt=IR[20:16] every cycle.
REQ-009 ALUOut SHALL load the ALU result every cycle.
REQ-010 Register file reads SHALL be asynchronous.
REQ-011 Register file writes SHALL occur on the rising edge when reg_write=1.
REQ-012 Register 0 SHALL always read 0; writes to register 0 are ignored.
REQ-013 Read during a same-cycle write SHALL return the old value.
REQ-014 ALU arithmetic SHALL be 32-bit wraparound; overflow is ignored; slt yields 1 or 0.
REQ-015 zero, mem_adr and mem_write_data SHALL be purely combinational from the current state and control inputs.
REQ-016 Simultaneous PCWrite and PCWriteCon SHALL load PC, as the logical OR of both conditions.

Reset
REQ-017 While rst=1 at a rising edge, the following SHALL clear to 0 and all writes are suppressed:
- PC, IR, A, B, MDR, ALUOut
- all 32 registers
REQ-018 Reset asserted mid-operation SHALL override any in-progress load on that edge.
REQ-019 After reset, mem_adr SHALL be 0 when IorD=0.

Structure
REQ-020 A shared package SHALL hold the encodings for alu_op, ALUSrcB, pc_src and RegWrDst.
REQ-021 The register file SHALL be a sub-module named reg_file.
REQ-022 The ALU SHALL be inline combinational logic.
REQ-023 Memory is external, module mem:
- ports (adr, write_data, mem_read, mem_write, clk, read_data)
- combinational read, synchronous write
- byte-addressed, word-aligned; contents initialised from a hex file

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Fetch loop: rst=1 for one edge, then PCWrite=1, pc_src=00, ALUSrcA=0, ALUSrcB=01, alu_op=000, IorD=0, IR_write=1 -> mem_adr = 0, 4, 8, 12 on successive cycles; IR = mem word at the previous PC.
- Branch taken: PCWriteCon=1, PCWrite=0, A=B=5 with alu_op=001 and pc_src=01, ALUOut=0x40 -> zero=1, PC=0x40; with A=5, B=6 -> PC unchanged.
- R-type: registers 1=7 and 2=3, IR encodes rs=1, rt=2, rd=3, alu_op=000, ALUSrcA=1, ALUSrcB=00; next cycle RegDst=1, RegWrDst=00, reg_write=1 -> register 3 = 10.
- Load path: IorD=1, ALUOut=0x10, memory word 0x10 = 0xDEADBEEF; next cycle RegDst=0, RegWrDst=01, reg_write=1 -> register rt = 0xDEADBEEF.
- Jump/jal: pc_src=10 with PC=0x10000004, IR[25:0]=0x0000040 -> PC=0x10000100; RegWrDst=10, reg_write=1 -> register 31 = old PC.
- Register 0 write of 0xFFFFFFFF -> reads 0; reset mid-run -> PC=0 and all registers 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared encodings for the multi-cycle datapath control inputs.
package datapath_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG_A  = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        WD_ALUOUT     = 2'b00,
        WD_MDR        = 2'b01,
        WD_PC         = 2'b10,
        WD_ALUOUT_ALT = 2'b11
    } reg_wr_dst_e;

    // Link register written by jump-and-link.
    localparam logic [4:0] RA_LINK = 5'd31;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous
// write port, register 0 hardwired to zero.
module reg_file
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Next register contents: writes to register 0 are dropped.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    // Register storage; reset clears every entry and suppresses the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Asynchronous reads return the pre-edge value during a same-cycle write.
    always_comb begin
        rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
        rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
    end

endmodule

// File: rtl/datapath.sv
// Multi-cycle MIPS-style datapath: PC, IR, MDR, A/B, ALUOut registers,
// inline ALU and an instantiated register file. Memory is external.
module datapath
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        PCWriteCon,
    input  logic        IorD,
    input  logic [31:0] mem_read_data,
    input  logic        IR_write,
    input  logic        RegDst,
    input  logic [1:0]  RegWrDst,
    input  logic        reg_write,
    input  logic        ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [2:0]  alu_op,
    input  logic [1:0]  pc_src,
    output logic        zero,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_write_data
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] aluout_q, aluout_d;

    logic [31:0] imm_ext;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [31:0] pc_next;
    logic        pc_en;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] rf_rd1, rf_rd2;
    logic [5:0]  unused_opcode;

    reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .we  (reg_write),
        .ra1 (ir_q[25:21]),
        .ra2 (ir_q[20:16]),
        .wa  (rf_wa),
        .wd  (rf_wd),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );

    // ALU operand selection and operation; zero flags a zero result.
    always_comb begin
        imm_ext       = sign_ext16(ir_q[15:0]);
        unused_opcode = ir_q[31:26];
        alu_a         = ALUSrcA ? a_q : pc_q;
        case (alu_src_b_e'(ALUSrcB))
            SRCB_REG:     alu_b = b_q;
            SRCB_FOUR:    alu_b = 32'd4;
            SRCB_IMM:     alu_b = imm_ext;
            SRCB_IMM_SH2: alu_b = {imm_ext[29:0], 2'b00};
            default:      alu_b = b_q;
        endcase
        case (alu_op_e'(alu_op))
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_SLT: alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_res = alu_a + alu_b;
        endcase
        zero = (alu_res == '0);
    end

    // Register-file write address and data; the PC path links to r31.
    always_comb begin
        rf_wa = RegDst ? ir_q[15:11] : ir_q[20:16];
        rf_wd = aluout_q;
        case (reg_wr_dst_e'(RegWrDst))
            WD_ALUOUT:     rf_wd = aluout_q;
            WD_MDR:        rf_wd = mdr_q;
            WD_PC: begin
                rf_wd = pc_q;
                rf_wa = RA_LINK;
            end
            WD_ALUOUT_ALT: rf_wd = aluout_q;
            default:       rf_wd = aluout_q;
        endcase
    end

    // Next-state values for the architectural and pipeline registers.
    always_comb begin
        pc_en = PCWrite | (PCWriteCon & zero);
        case (pc_src_e'(pc_src))
            PC_ALU:    pc_next = alu_res;
            PC_ALUOUT: pc_next = aluout_q;
            PC_JUMP:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
            PC_REG_A:  pc_next = a_q;
            default:   pc_next = alu_res;
        endcase
        pc_d     = pc_en ? pc_next : pc_q;
        ir_d     = IR_write ? mem_read_data : ir_q;
        mdr_d    = mem_read_data;
        a_d      = rf_rd1;
        b_d      = rf_rd2;
        aluout_d = alu_res;
    end

    // State registers with synchronous reset taking priority over loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mdr_q    <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mdr_q    <= mdr_d;
            aluout_q <= aluout_d;
        end
    end

    // Memory-side outputs.
    always_comb begin
        mem_adr        = IorD ? aluout_q : pc_q;
        mem_write_data = b_q;
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: table-driven ALU vectors plus directed
// multi-cycle sequences, with expectations queued on a scoreboard.
module tb_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, PCWriteCon, IorD, IR_write, RegDst, reg_write, ALUSrcA;
    logic [31:0] mem_read_data;
    logic [1:0]  RegWrDst, ALUSrcB, pc_src;
    logic [2:0]  alu_op;
    logic        zero;
    logic [31:0] mem_adr, mem_write_data;

    // Behavioural memory with an injection override for instruction/data words.
    logic [31:0] mem_arr [256];
    logic        force_en;
    logic [31:0] force_val;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        z;
    } alu_vec_t;

    exp_t     sb_q[$];
    alu_vec_t vecs[10];
    int       n_cmp  = 0;
    int       n_fail = 0;

    datapath dut (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .PCWriteCon     (PCWriteCon),
        .IorD           (IorD),
        .mem_read_data  (mem_read_data),
        .IR_write       (IR_write),
        .RegDst         (RegDst),
        .RegWrDst       (RegWrDst),
        .reg_write      (reg_write),
        .ALUSrcA        (ALUSrcA),
        .ALUSrcB        (ALUSrcB),
        .alu_op         (alu_op),
        .pc_src         (pc_src),
        .zero           (zero),
        .mem_adr        (mem_adr),
        .mem_write_data (mem_write_data)
    );

    always #5 clk = ~clk;

    always_comb mem_read_data = force_en ? force_val : mem_arr[mem_adr[9:2]];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string nm, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %h expected queued value", act);
            return;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
    endtask

    task automatic ctl_idle();
        PCWrite = 0; PCWriteCon = 0; IorD = 0; IR_write = 0; RegDst = 0;
        RegWrDst = 2'b00; reg_write = 0; ALUSrcA = 0; ALUSrcB = 2'b00;
        alu_op = 3'b000; pc_src = 2'b00;
    endtask

    task automatic load_ir(input logic [31:0] w);
        force_en  = 1;
        force_val = w;
        IR_write  = 1;
        tick();
        IR_write  = 0;
        force_en  = 0;
    endtask

    // IR selects rt=k, MDR captures v, then MDR is written to rt. The write
    // edge also loads B from the old register value.
    task automatic write_reg(input logic [4:0] k, input logic [31:0] v,
                             input logic [31:0] old_v, input bit chk_old);
        load_ir({6'h00, 5'd0, k, 16'h0000});
        force_en  = 1;
        force_val = v;
        tick();
        force_en  = 0;
        RegDst    = 0;
        RegWrDst  = 2'b01;
        reg_write = 1;
        if (chk_old) expect_v("read_during_write_old", old_v);
        tick();
        reg_write = 0;
        RegWrDst  = 2'b00;
        if (chk_old) check(mem_write_data);
    endtask

    task automatic check_reg(input string nm, input logic [4:0] k, input logic [31:0] v);
        expect_v(nm, v);
        load_ir({6'h00, 5'd0, k, 16'h0000});
        tick();
        check(mem_write_data);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA500_0000 + 32'(i);
        mem_arr[0] = 32'h1111_1111;
        mem_arr[1] = 32'h2222_2222;
        mem_arr[2] = 32'h0800_0020;   // j 0x80
        mem_arr[4] = 32'hDEAD_BEEF;

        vecs[0] = '{32'd7,        32'd3,        3'b000, 32'd10,       1'b0};
        vecs[1] = '{32'd5,        32'd5,        3'b001, 32'd0,        1'b1};
        vecs[2] = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00F000F0, 1'b0};
        vecs[3] = '{32'h0000FFFF, 32'hFFFF0000, 3'b011, 32'hFFFFFFFF, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'd1,        3'b100, 32'd1,        1'b0};
        vecs[5] = '{32'd1,        32'hFFFFFFFF, 3'b100, 32'd0,        1'b1};
        vecs[6] = '{32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        1'b1};
        vecs[7] = '{32'd2,        32'd3,        3'b111, 32'd5,        1'b0};
        vecs[8] = '{32'd0,        32'd1,        3'b001, 32'hFFFFFFFF, 1'b0};
        vecs[9] = '{32'h80000000, 32'h7FFFFFFF, 3'b100, 32'd1,        1'b0};

        force_en  = 0;
        force_val = '0;
        ctl_idle();

        // Reset with loads requested: reset must win.
        rst = 1; PCWrite = 1; reg_write = 1; IR_write = 1;
        tick();
        rst = 0;
        ctl_idle();
        expect_v("reset_pc", 32'h0);          check(mem_adr);
        expect_v("reset_b", 32'h0);           check(mem_write_data);
        expect_v("reset_zero", 32'h1);        check({31'd0, zero});
        IorD = 1; #1;
        expect_v("reset_aluout", 32'h0);      check(mem_adr);
        IorD = 0;

        // Fetch loop.
        PCWrite = 1; pc_src = 2'b00; ALUSrcA = 0; ALUSrcB = 2'b01;
        alu_op = 3'b000; IorD = 0; IR_write = 1;
        for (int i = 1; i <= 3; i++) begin
            expect_v("fetch_pc", 32'(4 * i));
            tick();
            check(mem_adr);
        end
        ctl_idle();
        // IR now holds the word fetched from 8 (j 0x80).
        PCWrite = 1; pc_src = 2'b10;
        expect_v("fetch_ir_jump", 32'h80);
        tick();
        check(mem_adr);
        ctl_idle();

        // ALU vector table.
        for (int i = 0; i < 10; i++) begin
            write_reg(5'd1, vecs[i].a, '0, 0);
            write_reg(5'd2, vecs[i].b, '0, 0);
            load_ir({6'h00, 5'd1, 5'd2, 16'h0000});
            tick();
            ALUSrcA = 1; ALUSrcB = 2'b00; alu_op = vecs[i].op;
            #1;
            expect_v($sformatf("alu_zero_%0d", i), {31'd0, vecs[i].z});
            check({31'd0, zero});
            expect_v($sformatf("alu_res_%0d", i), vecs[i].res);
            tick();
            IorD = 1; #1;
            check(mem_adr);
            ctl_idle();
        end

        // Read during a same-cycle write returns the old value.
        write_reg(5'd6, 32'h11, '0, 0);
        write_reg(5'd6, 32'h22, 32'h11, 1);
        check_reg("rdw_new", 5'd6, 32'h22);

        // R-type add r3 = r1 + r2.
        write_reg(5'd1, 32'd7, '0, 0);
        write_reg(5'd2, 32'd3, '0, 0);
        load_ir({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
        tick();
        ALUSrcA = 1; ALUSrcB = 2'b00; alu_op = 3'b000;
        tick();
        RegDst = 1; RegWrDst = 2'b00; reg_write = 1;
        tick();
        ctl_idle();
        check_reg("rtype_r3", 5'd3, 32'd10);

        // Load word: r5 = mem[0x10].
        load_ir({6'h23, 5'd0, 5'd5, 16'h0010});
        tick();
        ALUSrcA = 1; ALUSrcB = 2'b10; alu_op = 3'b000;
        tick();
        IorD = 1; #1;
        expect_v("load_adr", 32'h10);
        check(mem_adr);
        tick();
        RegDst = 0; RegWrDst = 2'b01; reg_write = 1;
        tick();
        ctl_idle();
        check_reg("load_r5", 5'd5, 32'hDEADBEEF);

        // Branch taken: A=B=5, ALUOut=5+0x3B=0x40.
        write_reg(5'd1, 32'd5, '0, 0);
        write_reg(5'd2, 32'd5, '0, 0);
        load_ir({6'h04, 5'd1, 5'd2, 16'h003B});
        tick();
        ALUSrcA = 1; ALUSrcB = 2'b10; alu_op = 3'b000;
        tick();
        ALUSrcB = 2'b00; alu_op = 3'b001; pc_src = 2'b01; PCWriteCon = 1;
        #1;
        expect_v("beq_zero_taken", 32'h1);
        check({31'd0, zero});
        expect_v("beq_taken_pc", 32'h40);
        tick();
        ctl_idle();
        check(mem_adr);

        // Branch not taken: B=6, ALUOut=0x60, PC stays 0x40.
        write_reg(5'd2, 32'd6, '0, 0);
        load_ir({6'h04, 5'd1, 5'd2, 16'h005B});
        tick();
        ALUSrcA = 1; ALUSrcB = 2'b10; alu_op = 3'b000;
        tick();
        ALUSrcB = 2'b00; alu_op = 3'b001; pc_src = 2'b01; PCWriteCon = 1;
        #1;
        expect_v("beq_zero_not_taken", 32'h0);
        check({31'd0, zero});
        expect_v("beq_not_taken_pc", 32'h40);
        tick();
        check(mem_adr);
        // PCWrite together with PCWriteCon loads even with zero=0.
        PCWrite = 1;
        expect_v("pcwrite_or_con", 32'hFFFFFFFF);
        tick();
        ctl_idle();
        check(mem_adr);

        // Jump-and-link from PC=0x10000004.
        write_reg(5'd1, 32'h10000004, '0, 0);
        load_ir({6'h00, 5'd1, 5'd0, 16'h0000});
        tick();
        PCWrite = 1; pc_src = 2'b11;
        expect_v("jr_pc", 32'h10000004);
        tick();
        ctl_idle();
        check(mem_adr);
        load_ir({6'h03, 26'h0000040});
        PCWrite = 1; pc_src = 2'b10; RegWrDst = 2'b10; reg_write = 1;
        expect_v("jal_pc", 32'h10000100);
        tick();
        ctl_idle();
        check(mem_adr);
        check_reg("jal_r31", 5'd31, 32'h10000004);

        // Register 0 ignores writes.
        write_reg(5'd0, 32'hFFFFFFFF, '0, 0);
        check_reg("r0_zero", 5'd0, 32'h0);

        // Reset mid-run with loads in flight.
        load_ir({6'h00, 5'd0, 5'd3, 16'h0000});
        tick();
        PCWrite = 1; ALUSrcB = 2'b01; reg_write = 1; RegWrDst = 2'b10; IR_write = 1;
        rst = 1;
        tick();
        rst = 0;
        ctl_idle();
        expect_v("midrst_pc", 32'h0);      check(mem_adr);
        expect_v("midrst_b", 32'h0);       check(mem_write_data);
        IorD = 1; #1;
        expect_v("midrst_aluout", 32'h0);  check(mem_adr);
        IorD = 0;
        check_reg("midrst_r3", 5'd3, 32'h0);
        check_reg("midrst_r5", 5'd5, 32'h0);
        check_reg("midrst_r6", 5'd6, 32'h0);
        check_reg("midrst_r31", 5'd31, 32'h0);

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
